// File: rtl/enemy_formation.sv
// enemy_formation: invader alive mask, marching offset, score and wave sequencing, clocked per frame.
module enemy_formation #(
   parameter int STEP_PX     = 2,
   parameter int PERIOD_FULL = 8,
   parameter int PERIOD_HALF = 4,
   parameter int PERIOD_LOW  = 2,
   parameter int WAVE_DELAY  = 60
) (
   input  logic            vsync,
   input  logic            reset,
   input  logic            pause,
   input  logic            ecollision,
   input  logic [6:0]      enemy_hit,
   output logic [9:0][5:0] enemy_status,
   output logic [9:0]      enemy_offset,
   output logic [5:0]      alive_count,
   output logic [13:0]     score,
   output logic            wave_clear
);
   typedef enum logic [1:0] {RUN, CLEARED, REFILL} state_t;
   state_t state, next_state;
   logic run, refill, dir_left, hit_ok, step, turn;
   logic [7:0] cnt, period;
   logic [3:0] col, min_col, max_col;
   logic [2:0] row;
   logic [6:0] pts;
   logic [14:0] score_sum;
   logic signed [10:0] left_x, right_x;
   logic signed [11:0] left_nx, right_nx;
   always_comb begin
      alive_count = '0;
      min_col = '0;
      max_col = '0;
      for (int c = 9; c >= 0; c--) if (|enemy_status[c]) min_col = 4'(c);
      for (int c = 0; c < 10; c++) begin
         if (|enemy_status[c]) max_col = 4'(c);
         for (int r = 0; r < 6; r++) alive_count = alive_count + 6'(enemy_status[c][r]);
      end
   end
   assign col = enemy_hit[6:3];
   assign row = enemy_hit[2:0];
   assign hit_ok = run && ecollision && col < 4'd10 && row < 3'd6 && enemy_status[col][row];
   assign pts = row < 3'd2 ? 7'd30 : row < 3'd4 ? 7'd20 : 7'd10;
   assign score_sum = {1'b0, score} + 15'(pts);
   assign period = alive_count >= 6'd40 ? 8'(PERIOD_FULL) :
                   alive_count >= 6'd20 ? 8'(PERIOD_HALF) :
                   alive_count >= 6'd5  ? 8'(PERIOD_LOW)  : 8'd1;
   assign step = run && !pause && cnt >= period - 8'd1;
   // Bounds come from the registered (pre-hit) mask, so a same-frame hit cannot move the edge.
   assign left_x   = {enemy_offset[9], enemy_offset} + {1'b0, min_col, 6'b0};
   assign right_x  = {enemy_offset[9], enemy_offset} + {1'b0, max_col, 6'b0} + 11'd32;
   assign left_nx  = 12'(left_x) - 12'(STEP_PX);
   assign right_nx = 12'(right_x) + 12'(STEP_PX);
   assign turn = dir_left ? left_nx[11] : right_nx > 12'sd640;
   always_ff @(posedge vsync or posedge reset)
      if (reset) state <= RUN;
      else state <= next_state;
   always_comb
      next_state = state == RUN     ? ((hit_ok && alive_count == 6'd1) ? CLEARED : RUN) :
                   state == CLEARED ? ((!pause && cnt == 8'(WAVE_DELAY - 1)) ? REFILL : CLEARED) :
                   RUN;
   always_comb begin
      run = state == RUN;
      refill = state == REFILL;
   end
   always_ff @(posedge vsync or posedge reset)
      if (reset) begin
         enemy_status <= '1;
         enemy_offset <= 10'd16;
         dir_left <= 1'b0;
         cnt <= '0;
         score <= '0;
         wave_clear <= 1'b0;
      end else begin
         wave_clear <= run && next_state == CLEARED;
         if (refill) begin
            enemy_status <= '1;
            enemy_offset <= 10'd16;
            dir_left <= 1'b0;
            cnt <= '0;
         end else if (run) begin
            if (hit_ok) begin
               enemy_status[col][row] <= 1'b0;
               score <= score_sum > 15'd9999 ? 14'd9999 : score_sum[13:0];
            end
            if (next_state == CLEARED) cnt <= '0;
            else if (!pause) cnt <= step ? '0 : cnt + 8'd1;
            if (step) begin
               dir_left <= dir_left ^ turn;
               enemy_offset <= (dir_left ^ turn) ? enemy_offset - 10'(STEP_PX) : enemy_offset + 10'(STEP_PX);
            end
         end else if (!pause) cnt <= cnt + 8'd1;
      end
endmodule

// File: tb/tb_enemy_formation.sv
// tb_enemy_formation: scoreboard bench driving frames through a reference model of the formation.
module tb_enemy_formation;
   logic vsync = 0, reset = 1, pause = 0, ecollision = 0;
   logic [6:0] enemy_hit = '0;
   logic [9:0][5:0] enemy_status;
   logic [9:0] enemy_offset;
   logic [5:0] alive_count;
   logic [13:0] score;
   logic wave_clear;
   typedef logic [90:0] snap_t;
   snap_t sb[$];
   int checks = 0, passes = 0;
   logic [9:0][5:0] m_st;
   int m_off, m_cnt, m_score, m_state;
   bit m_left, m_wc;

   enemy_formation dut (
      .vsync(vsync), .reset(reset), .pause(pause), .ecollision(ecollision), .enemy_hit(enemy_hit),
      .enemy_status(enemy_status), .enemy_offset(enemy_offset), .alive_count(alive_count),
      .score(score), .wave_clear(wave_clear)
   );

   always #5 vsync = ~vsync;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic snap_t actual();
      return {enemy_status, enemy_offset, score, alive_count, wave_clear};
   endfunction

   function automatic int s11(input int v);
      int w = ((v % 2048) + 2048) % 2048;
      return w >= 1024 ? w - 2048 : w;
   endfunction

   task automatic model(input bit p, input bit ec, input logic [6:0] h);
      int alive, mn = 0, mx = 0, per, so, lx, rx;
      int c = int'(h[6:3]), r = int'(h[2:0]);
      bit first = 1, hit;
      for (int i = 0; i < 10; i++)
         if (m_st[i] != 0) begin
            if (first) mn = i;
            first = 0;
            mx = i;
         end
      alive = $countones(m_st);
      so = m_off >= 512 ? m_off - 1024 : m_off;
      lx = s11(so + 64 * mn);
      rx = s11(so + 64 * mx + 32);
      m_wc = 0;
      if (m_state == 2) begin
         m_st = '1; m_off = 16; m_left = 0; m_cnt = 0; m_state = 0;
      end else if (m_state == 1) begin
         if (!p) begin
            if (m_cnt == 59) m_state = 2;
            m_cnt++;
         end
      end else begin
         hit = ec && c < 10 && r < 6;
         if (hit) hit = m_st[c][r];
         if (!p) begin
            per = alive >= 40 ? 8 : alive >= 20 ? 4 : alive >= 5 ? 2 : 1;
            if (m_cnt >= per - 1) begin
               m_cnt = 0;
               if (!m_left && rx + 2 > 640) m_left = 1;
               else if (m_left && lx - 2 < 0) m_left = 0;
               m_off = (m_off + (m_left ? 1022 : 2)) % 1024;
            end else m_cnt++;
         end
         if (hit) begin
            m_st[c][r] = 0;
            m_score = m_score + (r < 2 ? 30 : r < 4 ? 20 : 10);
            if (m_score > 9999) m_score = 9999;
            if (alive == 1) begin m_state = 1; m_wc = 1; m_cnt = 0; end
         end
      end
   endtask

   task automatic tick(input bit p, input bit ec, input logic [6:0] h);
      pause = p; ecollision = ec; enemy_hit = h;
      model(p, ec, h);
      sb.push_back({m_st, 10'(m_off), 14'(m_score), 6'($countones(m_st)), m_wc});
      @(posedge vsync); #1;
      pause = 0; ecollision = 0;
   endtask

   task automatic apply_reset();
      reset = 1; pause = 0; ecollision = 0;
      m_st = '1; m_off = 16; m_left = 0; m_cnt = 0; m_score = 0; m_state = 0; m_wc = 0;
      @(posedge vsync); #1;
      reset = 0;
   endtask

   task automatic kill_columns(input int lo, input int hi);
      snap_t exp;
      for (int c = lo; c <= hi; c++)
         for (int r = 0; r < 6; r++) begin
            tick(0, 1, {4'(c), 3'(r)});
            exp = sb.pop_front(); checks++;
            if (actual() !== exp) $display("FAIL kill c%0d r%0d: got %h want %h", c, r, actual(), exp); else passes++;
         end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (enemy_status !== '1) $display("FAIL reset_status: got %h want all ones", enemy_status); else passes++;
      checks++; if (enemy_offset !== 10'd16) $display("FAIL reset_offset: got %0d want 16", enemy_offset); else passes++;
      checks++; if (score !== 14'd0) $display("FAIL reset_score: got %0d want 0", score); else passes++;
      checks++; if (alive_count !== 6'd60) $display("FAIL reset_alive: got %0d want 60", alive_count); else passes++;
      checks++; if (wave_clear !== 1'b0) $display("FAIL reset_wave_clear: got %b want 0", wave_clear); else passes++;
   endtask

   task automatic test_march();
      snap_t exp;
      int mx = 0, want;
      for (int f = 1; f <= 158; f++) begin
         tick(0, 0, 0);
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL march f%0d: got %h want %h", f, actual(), exp); else passes++;
         if (int'(enemy_offset) > mx) mx = int'(enemy_offset);
         if (f == 7 || f == 8 || f == 72) begin
            want = f == 7 ? 16 : f == 8 ? 18 : 30;
            checks++;
            if (int'(enemy_offset) !== want) $display("FAIL march_offset f%0d: got %0d want %0d", f, enemy_offset, want); else passes++;
         end
      end
      checks++; if (mx !== 32) $display("FAIL march_max_offset: got %0d want 32", mx); else passes++;
   endtask

   task automatic test_hits();
      snap_t exp;
      apply_reset();
      tick(0, 1, {4'd3, 3'd1});
      exp = sb.pop_front(); checks++;
      if (actual() !== exp) $display("FAIL hit_first: got %h want %h", actual(), exp); else passes++;
      checks++; if (enemy_status[3][1] !== 1'b0 || score !== 14'd30 || alive_count !== 6'd59)
         $display("FAIL hit_values: got bit %b score %0d alive %0d want 0 30 59", enemy_status[3][1], score, alive_count); else passes++;
      tick(0, 1, {4'd3, 3'd1});
      exp = sb.pop_front(); checks++;
      if (actual() !== exp) $display("FAIL hit_repeat: got %h want %h", actual(), exp); else passes++;
      tick(0, 1, {4'd12, 3'd0});
      exp = sb.pop_front(); checks++;
      if (actual() !== exp) $display("FAIL hit_col12: got %h want %h", actual(), exp); else passes++;
      tick(0, 1, {4'd0, 3'd7});
      exp = sb.pop_front(); checks++;
      if (actual() !== exp) $display("FAIL hit_row7: got %h want %h", actual(), exp); else passes++;
      checks++; if (score !== 14'd30 || alive_count !== 6'd59)
         $display("FAIL hit_ignored: got score %0d alive %0d want 30 59", score, alive_count); else passes++;
      for (int f = 0; f < 10; f++) begin
         tick(1, f == 3, {4'd0, 3'd5});
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL hit_paused f%0d: got %h want %h", f, actual(), exp); else passes++;
      end
      checks++; if (score !== 14'd40 || enemy_status[0][5] !== 1'b0 || enemy_offset !== 10'd16)
         $display("FAIL hit_pause_values: got score %0d bit %b offset %0d want 40 0 16", score, enemy_status[0][5], enemy_offset); else passes++;
   endtask

   task automatic test_same_frame();
      snap_t exp;
      apply_reset();
      for (int f = 1; f <= 72; f++) begin
         tick(0, f <= 5 || f == 72, {4'd9, f == 72 ? 3'd5 : 3'(f - 1)});
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL same_frame f%0d: got %h want %h", f, actual(), exp); else passes++;
      end
      checks++; if (enemy_offset !== 10'd30 || enemy_status[9] !== 6'd0)
         $display("FAIL same_frame_turn: got offset %0d col9 %b want 30 000000", enemy_offset, enemy_status[9]); else passes++;
   endtask

   task automatic test_left_edge();
      snap_t exp;
      bit seen_neg = 0, turned = 0;
      int f = 0;
      logic [9:0] prev;
      apply_reset();
      kill_columns(0, 8);
      while (!turned && f < 1500) begin
         prev = enemy_offset;
         tick(0, 0, 0);
         f++;
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL left_edge f%0d: got %h want %h", f, actual(), exp); else passes++;
         if (enemy_offset >= 10'd960) seen_neg = 1;
         if (seen_neg && enemy_offset == prev + 10'd2) turned = 1;
      end
      checks++; if (!seen_neg) $display("FAIL left_edge_negative: got no offset >= 960 want one"); else passes++;
      checks++; if (!turned) $display("FAIL left_edge_turn: got no reversal in %0d frames want one", f); else passes++;
   endtask

   task automatic test_wave();
      snap_t exp;
      apply_reset();
      kill_columns(0, 9);
      checks++; if (score !== 14'd1200 || wave_clear !== 1'b1 || alive_count !== 6'd0)
         $display("FAIL wave_clear_entry: got score %0d wc %b alive %0d want 1200 1 0", score, wave_clear, alive_count); else passes++;
      for (int j = 1; j <= 66; j++) begin
         tick(j >= 20 && j < 25, j == 10 || j == 66, 7'd0);
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL wave j%0d: got %h want %h", j, actual(), exp); else passes++;
         if (j == 1) begin
            checks++; if (wave_clear !== 1'b0) $display("FAIL wave_pulse_width: got %b want 0", wave_clear); else passes++;
         end
         if (j == 65) begin
            checks++; if (enemy_status !== '0) $display("FAIL wave_early_refill: got %h want 0", enemy_status); else passes++;
         end
      end
      checks++; if (enemy_status !== '1 || enemy_offset !== 10'd16 || score !== 14'd1200)
         $display("FAIL wave_refill: got status %h offset %0d score %0d want all ones 16 1200", enemy_status, enemy_offset, score); else passes++;
   endtask

   task automatic test_saturate();
      snap_t exp;
      for (int w = 0; w < 8; w++) begin
         kill_columns(0, 9);
         for (int j = 0; j < 61; j++) begin
            tick(0, 0, 0);
            exp = sb.pop_front(); checks++;
            if (actual() !== exp) $display("FAIL saturate w%0d j%0d: got %h want %h", w, j, actual(), exp); else passes++;
         end
      end
      checks++; if (score !== 14'd9999) $display("FAIL saturate_score: got %0d want 9999", score); else passes++;
   endtask

   task automatic test_reset_cleared();
      snap_t exp;
      apply_reset();
      kill_columns(0, 9);
      for (int j = 0; j < 10; j++) begin
         tick(0, 0, 0);
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL reset_cleared j%0d: got %h want %h", j, actual(), exp); else passes++;
      end
      #2 reset = 1;
      #1;
      checks++; if (enemy_status !== '1 || score !== 14'd0 || enemy_offset !== 10'd16 || wave_clear !== 1'b0)
         $display("FAIL async_reset: got status %h score %0d offset %0d wc %b want all ones 0 16 0", enemy_status, score, enemy_offset, wave_clear); else passes++;
      apply_reset();
      for (int f = 1; f <= 8; f++) begin
         tick(0, 0, 0);
         exp = sb.pop_front(); checks++;
         if (actual() !== exp) $display("FAIL post_reset f%0d: got %h want %h", f, actual(), exp); else passes++;
      end
      checks++; if (enemy_offset !== 10'd18) $display("FAIL post_reset_march: got %0d want 18", enemy_offset); else passes++;
   endtask

   initial begin
      test_reset();
      test_march();
      test_hits();
      test_same_frame();
      test_left_edge();
      test_wave();
      test_saturate();
      test_reset_cleared();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
